// File: rtl/run_toggle_ctrl.sv
// Run/pause controller: synchronises and debounces one pushbutton and
// toggles the run enable of the downstream pattern generator once per
// accepted press. Release is debounced too but never toggles.
module run_toggle_ctrl #(
  parameter int unsigned DB_N    = 21,
  parameter bit          EN_INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  output logic en,
  output logic run_tick,
  output logic db_level
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam logic [DB_N-1:0] CNT_LOAD = {DB_N{1'b1}};

  logic            sync_q1;
  logic            btn_s;
  db_state_t       state, state_nxt;
  logic [DB_N-1:0] cnt, cnt_nxt;
  logic            en_nxt, tick_nxt, db_nxt;

  // Two-flop synchroniser; the only path from the raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= btn_run;
      btn_s   <= sync_q1;
    end
  end

  // State, window counter and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ZERO;
      cnt      <= '0;
      en       <= EN_INIT;
      run_tick <= 1'b0;
      db_level <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      en       <= en_nxt;
      run_tick <= tick_nxt;
      db_level <= db_nxt;
    end
  end

  // Next state: any level change inside a window aborts it; cnt==0 is
  // tested before decrement so the counter never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ZERO: begin
        if (btn_s) begin
          state_nxt = WAIT1;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!btn_s)           state_nxt = ZERO;
        else if (cnt != '0)   cnt_nxt   = cnt - 1'b1;
        else                  state_nxt = ONE;
      end
      ONE: begin
        if (!btn_s) begin
          state_nxt = WAIT0;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (btn_s)            state_nxt = ONE;
        else if (cnt != '0)   cnt_nxt   = cnt - 1'b1;
        else                  state_nxt = ZERO;
      end
      default: state_nxt = ZERO;
    endcase
  end

  // Outputs: tick and toggle only on a completed press window; the
  // debounced level follows the state being entered.
  always_comb begin
    tick_nxt = (state == WAIT1) && btn_s && (cnt == '0);
    en_nxt   = tick_nxt ? ~en : en;
    db_nxt   = (state_nxt == ONE) || (state_nxt == WAIT0);
  end

endmodule
